// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the windowed convolution MAC.
package conv_pkg;

  // Per-beat sideband travelling alongside the S1 products.
  typedef struct packed {
    logic first;
    logic last;
    logic relu;
    logic rnd;
  } beat_tag_t;

  // Minimum accumulator width that cannot overflow for any kernel, pixel and bias.
  function automatic int acc_width(input int ksize, input int channels,
                                   input int pixel_w, input int kernel_w);
    return kernel_w + pixel_w + 1 + $clog2(ksize * ksize * channels) + 1;
  endfunction

  function automatic int round_half(input int frac_w);
    return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// KSIZE^2 signed-by-unsigned multipliers with a product register,
// followed by a combinational adder tree feeding the accumulator stage.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int KSIZE    = 3,
  parameter int PIXEL_W  = 8,
  parameter int KERNEL_W = 12,
  parameter int SUM_W    = KERNEL_W + PIXEL_W + 1 + $clog2(KSIZE * KSIZE)
)(
  input  logic                                      clk_i,
  input  logic                                      reset_n,
  input  logic                                      en,
  input  logic [KSIZE-1:0][KSIZE-1:0][KERNEL_W-1:0] kern,
  input  logic [KSIZE-1:0][KSIZE-1:0][PIXEL_W-1:0]  pix,
  output logic signed [SUM_W-1:0]                   sum
);

  localparam int NT     = KSIZE * KSIZE;
  localparam int PROD_W = KERNEL_W + PIXEL_W + 1;

  logic signed [PROD_W-1:0] prod_q [NT];

  // Pixels are zero-extended by one bit so the multiply stays fully signed.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NT; i++) prod_q[i] <= '0;
    end else if (en) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          prod_q[r*KSIZE + c] <= PROD_W'($signed(kern[r][c])) *
                                 PROD_W'($signed({1'b0, pix[r][c]}));
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + SUM_W'(prod_q[i]);
  end

endmodule

// File: rtl/conv_window_mac.sv
// Multi-channel KSIZE x KSIZE convolution PE: kernel banks, channel sequencing,
// bias accumulate, round/saturate output stage and valid/ready handshake.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int KSIZE    = 3,
  parameter int CHANNELS = 3,
  parameter int PIXEL_W  = 8,
  parameter int KERNEL_W = 12,
  parameter int FRAC_W   = 4,
  parameter int OUT_W    = 8,
  parameter int ACC_W    = 28,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
  input  logic                                      clk_i,
  input  logic                                      reset_n,
  input  logic                                      kern_we_i,
  input  logic [CH_W-1:0]                           kern_ch_i,
  input  logic [KSIZE-1:0][KSIZE-1:0][KERNEL_W-1:0] kern_i,
  input  logic                                      bias_we_i,
  input  logic [ACC_W-1:0]                          bias_i,
  input  logic                                      relu_en_i,
  input  logic                                      round_en_i,
  input  logic                                      flush_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  input  logic [KSIZE-1:0][KSIZE-1:0][PIXEL_W-1:0]  s_pixel_i,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i,
  output logic [OUT_W-1:0]                          m_pixel_o
);

  localparam int NT     = KSIZE * KSIZE;
  localparam int SUM_W  = KERNEL_W + PIXEL_W + 1 + $clog2(NT);
  localparam int STAGES = 1;
  localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W+1)'(round_half(FRAC_W));
  localparam logic signed [ACC_W:0] UMAX = (ACC_W+1)'(2**OUT_W - 1);
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SMIN = (ACC_W+1)'(-(2**(OUT_W-1)));

  if (ACC_W < acc_width(KSIZE, CHANNELS, PIXEL_W, KERNEL_W)) begin : g_acc_w_err
    $error("conv_window_mac: ACC_W too narrow for KSIZE/CHANNELS/PIXEL_W/KERNEL_W");
  end

  logic [CHANNELS-1:0][KSIZE-1:0][KSIZE-1:0][KERNEL_W-1:0] kern_q;
  logic [KSIZE-1:0][KSIZE-1:0][KERNEL_W-1:0]               kern_sel;
  logic signed [ACC_W-1:0] bias_q, s1_bias, acc_q;
  logic [CH_W-1:0]         ch_cnt;
  logic                    ch_last, adv;
  logic [STAGES:0]         vld_pipe;   // [0] S1 products, [1] S2 accumulator
  beat_tag_t               s1_tag;
  logic                    s2_last, relu_q, rnd_q;
  logic signed [SUM_W-1:0] tree_sum;
  logic signed [ACC_W:0]   acc_ext, rnd_sum, v;
  logic [OUT_W-1:0]        pix_sat;

  assign adv       = !m_valid_o || m_ready_i;
  assign s_ready_o = adv;
  assign ch_last   = (ch_cnt == CH_W'(CHANNELS - 1));

  always_comb begin
    kern_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (ch_cnt == CH_W'(c)) kern_sel = kern_q[c];
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      kern_q <= '0;
      bias_q <= '0;
    end else begin
      if (bias_we_i) bias_q <= bias_i;
      for (int c = 0; c < CHANNELS; c++)
        if (kern_we_i && kern_ch_i == CH_W'(c)) kern_q[c] <= kern_i;
    end
  end

  conv_mac_tree #(
    .KSIZE(KSIZE), .PIXEL_W(PIXEL_W), .KERNEL_W(KERNEL_W), .SUM_W(SUM_W)
  ) u_tree (
    .clk_i(clk_i), .reset_n(reset_n), .en(adv),
    .kern(kern_sel), .pix(s_pixel_i), .sum(tree_sum)
  );

  // Widen by one bit so adding the rounding constant can never wrap.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
    rnd_sum = acc_ext + (rnd_q ? ROUND_HALF : '0);
    v       = rnd_sum >>> FRAC_W;
    if (relu_q)
      pix_sat = v[ACC_W] ? '0 : (v > UMAX) ? '1 : v[OUT_W-1:0];
    else
      pix_sat = (v < SMIN) ? {1'b1, {(OUT_W-1){1'b0}}} :
                (v > SMAX) ? {1'b0, {(OUT_W-1){1'b1}}} : v[OUT_W-1:0];
  end

  // Bias is latched with each beat so a write on the accept edge is not seen.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt    <= '0;
      vld_pipe  <= '0;
      s1_tag    <= '0;
      s1_bias   <= '0;
      s2_last   <= 1'b0;
      acc_q     <= '0;
      relu_q    <= 1'b0;
      rnd_q     <= 1'b0;
      m_valid_o <= 1'b0;
      m_pixel_o <= '0;
    end else if (flush_i) begin
      ch_cnt    <= '0;
      vld_pipe  <= '0;
      m_valid_o <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], s_valid_i};
      if (s_valid_i) begin
        s1_tag  <= '{first: (ch_cnt == '0), last: ch_last,
                     relu: relu_en_i, rnd: round_en_i};
        s1_bias <= bias_q;
        ch_cnt  <= ch_last ? '0 : CH_W'(ch_cnt + 1'b1);
      end
      if (vld_pipe[0]) begin
        acc_q   <= (s1_tag.first ? s1_bias : acc_q) + ACC_W'(tree_sum);
        s2_last <= s1_tag.last;
        if (s1_tag.first) begin
          relu_q <= s1_tag.relu;
          rnd_q  <= s1_tag.rnd;
        end
      end
      m_valid_o <= vld_pipe[1] && s2_last;
      if (vld_pipe[1] && s2_last) m_pixel_o <= pix_sat;
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac (KSIZE=3, CHANNELS=3): directed cases
// plus randomized traffic with backpressure against an arithmetic reference model.
module tb_conv_window_mac;

  typedef logic [2:0][2:0][7:0]  win_t;
  typedef logic [2:0][2:0][11:0] kwin_t;

  logic        clk_i = 1'b0, reset_n = 1'b0;
  logic        kern_we_i = 1'b0, bias_we_i = 1'b0;
  logic [1:0]  kern_ch_i = '0;
  kwin_t       kern_i = '0;
  logic [27:0] bias_i = '0;
  logic        relu_en_i = 1'b0, round_en_i = 1'b0, flush_i = 1'b0;
  logic        s_valid_i = 1'b0, s_ready_o, m_valid_o, m_ready_i = 1'b0;
  win_t        s_pixel_i = '0;
  logic [7:0]  m_pixel_o;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  longint      kern_m[3][3][3];
  longint      bias_m = 0, acc_m = 0;
  int          ch_m = 0;
  bit          relu_m, round_m;
  int          rdy_mode = 0;   // 0 always ready, 1 random with stall bursts, 2 never ready
  int          rdy_cyc = 0;

  conv_window_mac dut (
    .clk_i(clk_i), .reset_n(reset_n), .kern_we_i(kern_we_i), .kern_ch_i(kern_ch_i),
    .kern_i(kern_i), .bias_we_i(bias_we_i), .bias_i(bias_i), .relu_en_i(relu_en_i),
    .round_en_i(round_en_i), .flush_i(flush_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_pixel_i(s_pixel_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_pixel_o(m_pixel_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum over channels of kernel*pixel plus bias, then shift/round and clamp.
  function automatic void model_accept(input win_t p, input bit relu, input bit rnd);
    longint v;
    if (ch_m == 0) begin
      acc_m = bias_m; relu_m = relu; round_m = rnd;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc_m += kern_m[ch_m][r][c] * longint'(p[r][c]);
    ch_m++;
    if (ch_m == 3) begin
      v = round_m ? (acc_m + 8) >>> 4 : acc_m >>> 4;
      if (relu_m) v = (v < 0) ? 0 : (v > 255) ? 255 : v;
      else        v = (v < -128) ? -128 : (v > 127) ? 127 : v;
      exp_q.push_back(8'(v));
      ch_m = 0;
    end
  endfunction

  function automatic win_t wfill(input logic [7:0] centre, input logic [7:0] other);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = (r == 1 && c == 1) ? centre : other;
    return w;
  endfunction

  function automatic win_t wrand();
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'($urandom);
    return w;
  endfunction

  function automatic kwin_t kfill(input logic [11:0] centre, input logic [11:0] other);
    kwin_t k;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) k[r][c] = (r == 1 && c == 1) ? centre : other;
    return k;
  endfunction

  task automatic write_kern(input int ch, input kwin_t k);
    @(negedge clk_i);
    kern_we_i = 1'b1; kern_ch_i = 2'(ch); kern_i = k;
    @(posedge clk_i); #1 kern_we_i = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) kern_m[ch][r][c] = longint'($signed(k[r][c]));
  endtask

  task automatic write_bias(input longint b);
    @(negedge clk_i);
    bias_we_i = 1'b1; bias_i = 28'(b);
    @(posedge clk_i); #1 bias_we_i = 1'b0;
    bias_m = b;
  endtask

  task automatic send_beat(input win_t p, input bit relu, input bit rnd);
    int n = 0;
    @(negedge clk_i);
    s_valid_i = 1'b1; s_pixel_i = p; relu_en_i = relu; round_en_i = rnd;
    #1;
    while (!s_ready_o && n < 500) begin
      @(negedge clk_i); #1; n++;
    end
    if (!s_ready_o) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got s_ready 0 expected 1 at %0t", $time);
    end else model_accept(p, relu, rnd);
    @(posedge clk_i); #1 s_valid_i = 1'b0;
  endtask

  task automatic send_pixel(input win_t p, input bit relu, input bit rnd);
    for (int c = 0; c < 3; c++) send_beat(p, relu, rnd);
  endtask

  task automatic do_flush();
    @(negedge clk_i);
    flush_i = 1'b1; s_valid_i = 1'b1; s_pixel_i = wrand();
    @(posedge clk_i); #1;
    flush_i = 1'b0; s_valid_i = 1'b0;
    ch_m = 0;
  endtask

  initial forever begin
    @(negedge clk_i);
    case (rdy_mode)
      0: m_ready_i = 1'b1;
      1: begin
        rdy_cyc++;
        m_ready_i = (rdy_cyc % 25 < 5) ? 1'b0 : ($urandom % 4 != 0);
      end
      default: m_ready_i = 1'b0;
    endcase
  end

  // Monitor: every output handshake pops one expected pixel.
  initial forever begin
    @(negedge clk_i); #2;
    if (reset_n) begin
      if (m_valid_o && !m_ready_i) chk("s_ready_blocked", 32'(s_ready_o), 32'd0);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_output: got %0h expected none at %0t", m_pixel_o, $time);
        end else chk("pixel", 32'(m_pixel_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    foreach (kern_m[a, b, c]) kern_m[a][b][c] = 0;
    #2;
    chk("reset_m_valid", 32'(m_valid_o), 32'd0);
    chk("reset_m_pixel", 32'(m_pixel_o), 32'd0);
    chk("reset_s_ready", 32'(s_ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    reset_n = 1'b1;

    // T1: only channel 0 contributes, kernel 1.0, pixels 10 -> 90; latency 3
    write_kern(0, kfill(12'd16, 12'd16));
    write_kern(1, '0);
    write_kern(2, '0);
    write_bias(0);
    send_beat(wfill(8'd10, 8'd10), 1'b1, 1'b0);
    send_beat(wfill(8'd10, 8'd10), 1'b1, 1'b0);
    send_beat(wfill(8'd10, 8'd10), 1'b1, 1'b0);
    @(posedge clk_i); #1 chk("latency_early", 32'(m_valid_o), 32'd0);
    @(posedge clk_i); #1 chk("latency_3", 32'(m_valid_o), 32'd1);

    // T2: saturation in both modes
    for (int c = 0; c < 3; c++) write_kern(c, kfill(12'h7FF, 12'h7FF));
    send_pixel(wfill(8'd255, 8'd255), 1'b1, 1'b0);
    write_kern(0, kfill(12'hFF0, 12'hFF0));
    write_kern(1, '0);
    write_kern(2, '0);
    send_pixel(wfill(8'd10, 8'd10), 1'b1, 1'b0);
    send_pixel(wfill(8'd10, 8'd10), 1'b0, 1'b0);

    // T3: per-channel centre coefficients plus bias 2.0
    for (int c = 0; c < 3; c++) write_kern(c, kfill(12'(16 * (c + 1)), 12'd0));
    write_bias(32);
    send_pixel(wfill(8'd5, 8'($urandom)), 1'b1, 1'b0);

    // T4: rounding vs truncation, both signs
    write_kern(0, kfill(12'd8, 12'd0));
    write_kern(1, '0);
    write_kern(2, '0);
    write_bias(0);
    send_pixel(wfill(8'd3, 8'd0), 1'b0, 1'b1);
    send_pixel(wfill(8'd3, 8'd0), 1'b0, 1'b0);
    write_kern(0, kfill(12'hFF8, 12'd0));
    send_pixel(wfill(8'd3, 8'd0), 1'b0, 1'b1);
    send_pixel(wfill(8'd3, 8'd0), 1'b0, 1'b0);

    // T6: flush a partial pixel, then flush a pending output
    send_beat(wfill(8'd3, 8'd0), 1'b0, 1'b0);
    send_beat(wfill(8'd3, 8'd0), 1'b0, 1'b0);
    do_flush();
    chk("flush_partial_valid", 32'(m_valid_o), 32'd0);
    send_pixel(wfill(8'd3, 8'd0), 1'b0, 1'b1);
    repeat (4) @(posedge clk_i);
    rdy_mode = 2;
    send_pixel(wfill(8'd200, 8'd0), 1'b1, 1'b0);
    repeat (4) @(posedge clk_i);
    #1 chk("pending_valid", 32'(m_valid_o), 32'd1);
    do_flush();
    chk("flush_pending_valid", 32'(m_valid_o), 32'd0);
    void'(exp_q.pop_back());
    rdy_mode = 0;
    repeat (4) @(posedge clk_i);
    #1 chk("flush_no_output", 32'(m_valid_o), 32'd0);
    send_pixel(wfill(8'd7, 8'd1), 1'b0, 1'b0);

    // Async reset mid-pixel with an output pending
    repeat (4) @(posedge clk_i);
    rdy_mode = 2;
    send_pixel(wfill(8'd9, 8'd0), 1'b1, 1'b0);
    send_beat(wfill(8'd9, 8'd0), 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(m_valid_o), 32'd0);
    chk("async_reset_pixel", 32'(m_pixel_o), 32'd0);
    exp_q.delete();
    ch_m = 0; bias_m = 0;
    foreach (kern_m[a, b, c]) kern_m[a][b][c] = 0;
    @(negedge clk_i) reset_n = 1'b1;
    rdy_mode = 0;
    send_pixel(wrand(), 1'b0, 1'b0);

    // T5: randomized kernels, bias, modes, gaps and downstream backpressure
    for (int c = 0; c < 3; c++) begin
      kwin_t k;
      for (int r = 0; r < 3; r++)
        for (int q = 0; q < 3; q++) k[r][q] = 12'($signed($urandom_range(0, 12)) - 6);
      write_kern(c, k);
    end
    write_bias(longint'($urandom_range(0, 65535)) - 32768);
    rdy_mode = 1;
    for (int px = 0; px < 30; px++)
      for (int c = 0; c < 3; c++) begin
        if ($urandom % 3 == 0) @(negedge clk_i);
        send_beat(wrand(), 1'($urandom), 1'($urandom));
      end

    rdy_mode = 0;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk_i); n++;
      end
      if (exp_q.size() != 0) begin
        vectors++; miscompares++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end
    repeat (4) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
